// File: rtl/pa_dfs_req_ctrl.sv
// DFS request controller: halts the core through a req/ack four-phase
// handshake, opens the clock-ratio switch window while the core is halted,
// then releases the core and reports completion (or timeout abort).
module pa_dfs_req_ctrl #(
  parameter int unsigned SWITCH_CYC = 16,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned RATIO_W    = 3
) (
  input  logic               halt_clk,
  input  logic               cpurst_b,
  input  logic               pmu_dfs_start,
  input  logic [RATIO_W-1:0] pmu_dfs_ratio,
  input  logic               cpu_pad_dfs_ack,
  output logic               pad_cpu_dfs_req,
  output logic [RATIO_W-1:0] pad_sysio_clkratio,
  output logic               clk_switch_en,
  output logic               dfs_busy,
  output logic               dfs_done,
  output logic               dfs_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SWITCH = 2'd2,
    REL    = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] SW_LOAD = 16'(SWITCH_CYC - 1);

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic [RATIO_W-1:0]   ratio_q, ratio_d;
  logic [RATIO_W-1:0]   tgt_q, tgt_d;
  logic                 sw_en_q, sw_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 err_flag_q, err_flag_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 ack_meta_q;
  logic                 ack_s_q;

  // Two-flop synchroniser for the core's ack.
  always_ff @(posedge halt_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= cpu_pad_dfs_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge halt_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      ratio_q    <= '0;
      tgt_q      <= '0;
      sw_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ratio_q    <= ratio_d;
      tgt_q      <= tgt_d;
      sw_en_q    <= sw_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ratio_d    = ratio_q;
    tgt_d      = tgt_q;
    sw_en_d    = sw_en_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        // A start is only honoured once the previous ack has fully dropped.
        if (pmu_dfs_start && !ack_s_q) begin
          if (pmu_dfs_ratio != ratio_q) begin
            tgt_d   = pmu_dfs_ratio;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack_s_q) begin
          sw_en_d = 1'b1;
          cnt_d   = SW_LOAD;
          state_d = SWITCH;
        end else if (cnt_q == TO_LAST) begin
          req_d      = 1'b0;
          err_flag_d = 1'b1;
          state_d    = REL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SWITCH: begin
        if (cnt_q == '0) begin
          ratio_d = tgt_q;
          sw_en_d = 1'b0;
          req_d   = 1'b0;
          state_d = REL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      REL: begin
        if (!ack_s_q) begin
          done_d     = 1'b1;
          err_d      = err_flag_q;
          err_flag_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign pad_cpu_dfs_req    = req_q;
  assign pad_sysio_clkratio = ratio_q;
  assign clk_switch_en      = sw_en_q;
  assign dfs_busy           = busy_q;
  assign dfs_done           = done_q;
  assign dfs_err            = err_q;

endmodule

// File: tb/tb_pa_dfs_req_ctrl.sv
// Directed bench for pa_dfs_req_ctrl (SWITCH_CYC=16, TIMEOUT=8).
module tb_pa_dfs_req_ctrl;

  logic       halt_clk = 1'b0;
  logic       cpurst_b;
  logic       pmu_dfs_start;
  logic [2:0] pmu_dfs_ratio;
  logic       cpu_pad_dfs_ack;
  logic       pad_cpu_dfs_req;
  logic [2:0] pad_sysio_clkratio;
  logic       clk_switch_en;
  logic       dfs_busy;
  logic       dfs_done;
  logic       dfs_err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  pa_dfs_req_ctrl #(
    .SWITCH_CYC(16),
    .TIMEOUT   (8),
    .RATIO_W   (3)
  ) dut (
    .halt_clk          (halt_clk),
    .cpurst_b          (cpurst_b),
    .pmu_dfs_start     (pmu_dfs_start),
    .pmu_dfs_ratio     (pmu_dfs_ratio),
    .cpu_pad_dfs_ack   (cpu_pad_dfs_ack),
    .pad_cpu_dfs_req   (pad_cpu_dfs_req),
    .pad_sysio_clkratio(pad_sysio_clkratio),
    .clk_switch_en     (clk_switch_en),
    .dfs_busy          (dfs_busy),
    .dfs_done          (dfs_done),
    .dfs_err           (dfs_err)
  );

  always #5 halt_clk = ~halt_clk;

  // Count completion pulses away from the active edge.
  always @(negedge halt_clk) if (dfs_done === 1'b1) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge halt_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // From inside SWITCH with ack high: wait for req to fall, drop ack two
  // cycles later, then wait for the completion pulse.
  task automatic finish_xfer(input logic [2:0] exp_ratio, input string tag);
    int k;
    k = 0;
    while (pad_cpu_dfs_req === 1'b1 && k < 40) begin step(); k++; end
    chk({tag, "_req_fall"}, pad_cpu_dfs_req, 0);
    chk({tag, "_ratio"}, pad_sysio_clkratio, exp_ratio);
    step();
    step();
    cpu_pad_dfs_ack = 1'b0;
    k = 0;
    while (dfs_done !== 1'b1 && k < 10) begin step(); k++; end
    chk({tag, "_done"}, dfs_done, 1);
    chk({tag, "_err"}, dfs_err, 0);
  endtask

  initial begin
    int n;
    int d0;
    logic sw_seen;

    cpurst_b        = 1'b0;
    pmu_dfs_start   = 1'b0;
    pmu_dfs_ratio   = 3'd0;
    cpu_pad_dfs_ack = 1'b0;
    repeat (2) @(posedge halt_clk);
    #1;
    chk("rst_req",   pad_cpu_dfs_req, 0);
    chk("rst_ratio", pad_sysio_clkratio, 0);
    chk("rst_swen",  clk_switch_en, 0);
    chk("rst_busy",  dfs_busy, 0);
    chk("rst_done",  dfs_done, 0);
    chk("rst_err",   dfs_err, 0);
    cpurst_b = 1'b1;
    step();

    // 1. Normal switch 0 -> 3.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd3;
    chk("t1_req_pre", pad_cpu_dfs_req, 0);
    step();
    pmu_dfs_start = 1'b0;
    chk("t1_req_rise", pad_cpu_dfs_req, 1);
    chk("t1_busy", dfs_busy, 1);
    step(); step();
    cpu_pad_dfs_ack = 1'b1;
    step(); step();
    chk("t1_swen_pre", clk_switch_en, 0);
    step();
    chk("t1_swen_on", clk_switch_en, 1);
    chk("t1_ratio_hold", pad_sysio_clkratio, 0);
    n = 1;
    repeat (15) begin step(); if (clk_switch_en === 1'b1) n++; end
    chk("t1_swen_len", n, 16);
    step();
    chk("t1_swen_off", clk_switch_en, 0);
    chk("t1_req_fall", pad_cpu_dfs_req, 0);
    chk("t1_ratio_new", pad_sysio_clkratio, 3);
    chk("t1_busy_rel", dfs_busy, 1);
    step(); step();
    cpu_pad_dfs_ack = 1'b0;
    step();
    chk("t1_done_e1", dfs_done, 0);
    step();
    chk("t1_done_e2", dfs_done, 0);
    step();
    chk("t1_done", dfs_done, 1);
    chk("t1_err", dfs_err, 0);
    chk("t1_busy_end", dfs_busy, 0);
    step();
    chk("t1_done_pulse", dfs_done, 0);

    // 3. Same ratio: immediate completion, no handshake.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd3;
    step();
    pmu_dfs_start = 1'b0;
    chk("t3_done", dfs_done, 1);
    chk("t3_err", dfs_err, 0);
    chk("t3_req", pad_cpu_dfs_req, 0);
    chk("t3_busy", dfs_busy, 0);
    step();
    chk("t3_done_pulse", dfs_done, 0);

    // 4. Start while busy is ignored; 3 -> 6.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd6;
    step();
    pmu_dfs_start = 1'b0;
    chk("t4_req", pad_cpu_dfs_req, 1);
    step(); step();
    cpu_pad_dfs_ack = 1'b1;
    step(); step(); step();
    chk("t4_swen", clk_switch_en, 1);
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd5;
    step();
    pmu_dfs_start = 1'b0;
    d0 = done_cnt;
    finish_xfer(3'd6, "t4");
    step(); step();
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_req_idle", pad_cpu_dfs_req, 0);
    chk("t4_busy_idle", dfs_busy, 0);

    // 2. Timeout with ack never asserted; 6 -> 2 aborts.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd2;
    step();
    pmu_dfs_start = 1'b0;
    n = 1;
    sw_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      sw_seen = sw_seen | clk_switch_en;
      if (pad_cpu_dfs_req === 1'b1) n++;
      else break;
    end
    chk("t2_req_len", n, 8);
    chk("t2_ratio", pad_sysio_clkratio, 6);
    chk("t2_swen_never", sw_seen, 0);
    step();
    chk("t2_done", dfs_done, 1);
    chk("t2_err", dfs_err, 1);
    chk("t2_busy", dfs_busy, 0);

    // 5. Late ack: synchronised ack arrives just after the timeout.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd1;
    step();
    pmu_dfs_start = 1'b0;
    repeat (6) step();
    cpu_pad_dfs_ack = 1'b1;
    step(); step();
    chk("t5_req_fall", pad_cpu_dfs_req, 0);
    chk("t5_swen", clk_switch_en, 0);
    step();
    chk("t5_hold1", dfs_done, 0);
    step();
    chk("t5_hold2", dfs_done, 0);
    cpu_pad_dfs_ack = 1'b0;
    step();
    chk("t5_hold3", dfs_done, 0);
    step();
    chk("t5_hold4", dfs_done, 0);
    chk("t5_busy_rel", dfs_busy, 1);
    step();
    chk("t5_done", dfs_done, 1);
    chk("t5_err", dfs_err, 1);
    chk("t5_ratio", pad_sysio_clkratio, 6);
    chk("t5_busy_end", dfs_busy, 0);

    // Four-phase: start ignored while synchronised ack is still high.
    cpu_pad_dfs_ack = 1'b1;
    step(); step();
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd4;
    step();
    pmu_dfs_start = 1'b0;
    chk("fp_req", pad_cpu_dfs_req, 0);
    chk("fp_done", dfs_done, 0);
    chk("fp_busy", dfs_busy, 0);
    cpu_pad_dfs_ack = 1'b0;
    repeat (3) step();

    // Ack and timeout on the same cycle: ack wins; 6 -> 7.
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd7;
    step();
    pmu_dfs_start = 1'b0;
    repeat (5) step();
    cpu_pad_dfs_ack = 1'b1;
    step(); step();
    chk("tie_req_pre", pad_cpu_dfs_req, 1);
    chk("tie_swen_pre", clk_switch_en, 0);
    step();
    chk("tie_swen", clk_switch_en, 1);
    chk("tie_req", pad_cpu_dfs_req, 1);
    finish_xfer(3'd7, "tie");

    // 6. Reset inside the switch window, then a fresh transfer 0 -> 2.
    step();
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd5;
    step();
    pmu_dfs_start = 1'b0;
    step(); step();
    cpu_pad_dfs_ack = 1'b1;
    step(); step(); step();
    chk("t6_swen", clk_switch_en, 1);
    repeat (4) step();
    d0 = done_cnt;
    #2 cpurst_b = 1'b0;
    #1;
    chk("t6_rst_req", pad_cpu_dfs_req, 0);
    chk("t6_rst_swen", clk_switch_en, 0);
    chk("t6_rst_ratio", pad_sysio_clkratio, 0);
    chk("t6_rst_busy", dfs_busy, 0);
    cpu_pad_dfs_ack = 1'b0;
    step(); step();
    cpurst_b = 1'b1;
    step();
    chk("t6_no_done", done_cnt - d0, 0);
    pmu_dfs_start = 1'b1; pmu_dfs_ratio = 3'd2;
    step();
    pmu_dfs_start = 1'b0;
    chk("t6_req_new", pad_cpu_dfs_req, 1);
    chk("t6_busy_new", dfs_busy, 1);
    step(); step();
    cpu_pad_dfs_ack = 1'b1;
    finish_xfer(3'd2, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
